// File: rtl/labs_pkg.sv
// Shared types and helpers for the LABS sidelobe-energy evaluator.
package labs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Width of a signed correlation term C_k for sequence length n.
    function automatic int corr_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Unsigned add that clamps at 2^w-1 instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [63:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (64'd1 << w) - 64'd1;
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/labs_corr_term.sv
// Combinational C_k^2 for one lag k: mask, XOR, popcount, square.
// Latency 0; no handshake, purely combinational.
module labs_corr_term
    import labs_pkg::*;
#(
    parameter int  SEQ_WIDTH = 16,
    localparam int CW        = corr_width(SEQ_WIDTH),
    localparam int KW        = $clog2(SEQ_WIDTH)
) (
    input  logic [SEQ_WIDTH-1:0] seq,
    input  logic [KW-1:0]        k,
    output logic [2*CW-1:0]      sq
);

    logic [SEQ_WIDTH-1:0] diff;
    logic [CW-1:0]        pc;
    logic [CW-1:0]        c;
    logic [CW-1:0]        mag;

    // Each differing pair contributes -1 instead of +1, hence C_k = (N-k) - 2*pc.
    always_comb begin
        diff = (seq ^ (seq >> k)) & ({SEQ_WIDTH{1'b1}} >> k);
        pc   = '0;
        for (int i = 0; i < SEQ_WIDTH; i++) begin
            pc = pc + CW'(diff[i]);
        end
        c   = CW'(SEQ_WIDTH) - CW'(k) - (pc << 1);
        mag = c[CW-1] ? CW'(-c) : c;
        sq  = (2*CW)'(mag) * (2*CW)'(mag);
    end

endmodule

// File: rtl/labs_energy_eval.sv
// Sequential LABS energy evaluator: one lag per cycle, latency N, II >= N+1.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
// Optional LABS_EARLY_ABORT_EN adds e_bound and drops candidates exceeding it.
module labs_energy_eval
    import labs_pkg::*;
#(
    parameter int SEQ_WIDTH = 16,
    parameter int E_WIDTH   = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEQ_WIDTH-1:0] in_seq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEQ_WIDTH-1:0] out_seq,
    output logic [E_WIDTH-1:0]   out_energy,
    output logic                 busy
`ifdef LABS_EARLY_ABORT_EN
    ,
    input  logic [E_WIDTH-1:0]   e_bound
`endif
);

    localparam int CORR_WIDTH = corr_width(SEQ_WIDTH);
    localparam int KW         = $clog2(SEQ_WIDTH);
    localparam int SQ_W       = 2 * CORR_WIDTH;

    state_t               state;
    logic [KW-1:0]        k;
    logic [E_WIDTH-1:0]   acc;
    logic [SEQ_WIDTH-1:0] seq_r;
    logic [SQ_W-1:0]      sq;
    logic [E_WIDTH-1:0]   acc_next;

    labs_corr_term #(.SEQ_WIDTH(SEQ_WIDTH)) u_term (
        .seq (seq_r),
        .k   (k),
        .sq  (sq)
    );

    assign acc_next = E_WIDTH'(sat_add(64'(acc), 64'(sq), E_WIDTH));
    assign in_ready = (state == IDLE) && !wb_rst_i;
    assign busy     = (state != IDLE);

`ifdef LABS_EARLY_ABORT_EN
    localparam int SW = ((E_WIDTH > SQ_W) ? E_WIDTH : SQ_W) + 1;
    logic [SW-1:0] sum_wide;
    logic          over_bound;
    assign sum_wide   = SW'(acc) + SW'(sq);
    assign over_bound = sum_wide > SW'(e_bound);
`else
    logic over_bound;
    assign over_bound = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            k          <= KW'(1);
            acc        <= '0;
            seq_r      <= '0;
            out_valid  <= 1'b0;
            out_seq    <= '0;
            out_energy <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        seq_r <= in_seq;
                        k     <= KW'(1);
                        acc   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (over_bound) begin
                        state <= IDLE;
                    end else if (k == KW'(SEQ_WIDTH - 1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_seq    <= seq_r;
                        out_energy <= acc_next;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_labs_energy_eval.sv
// Self-checking bench for labs_energy_eval: N=16/E=16, N=13/E=16, N=16/E=8 instances.
// Honours LABS_EARLY_ABORT_EN when defined.
module tb_labs_energy_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  iv, ir, ov, bsy, ordy;
    logic [15:0] is_ [3];
    logic [15:0] os  [3];
    logic [15:0] oe  [3];
    logic [15:0] eb  [3];
    logic [12:0] os13;
    logic [7:0]  oe8;

    assign os[1] = {3'b000, os13};
    assign oe[2] = {8'h00, oe8};

    labs_energy_eval #(.SEQ_WIDTH(16), .E_WIDTH(16)) u16 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_seq(is_[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_seq(os[0]), .out_energy(oe[0]), .busy(bsy[0])
`ifdef LABS_EARLY_ABORT_EN
        , .e_bound(eb[0])
`endif
    );

    labs_energy_eval #(.SEQ_WIDTH(13), .E_WIDTH(16)) u13 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_seq(is_[1][12:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_seq(os13), .out_energy(oe[1]), .busy(bsy[1])
`ifdef LABS_EARLY_ABORT_EN
        , .e_bound(eb[1])
`endif
    );

    labs_energy_eval #(.SEQ_WIDTH(16), .E_WIDTH(8)) u8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_seq(is_[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_seq(os[2]), .out_energy(oe8), .busy(bsy[2])
`ifdef LABS_EARLY_ABORT_EN
        , .e_bound(eb[2][7:0])
`endif
    );

    typedef struct {
        int          sel;
        logic [15:0] seq;
        int          exp_e;
        bit          bp;
    } vec_t;

    typedef struct {
        logic [15:0] seq;
        int          energy;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Energy straight from the definition, independent of the popcount form.
    function automatic int model_energy(input logic [15:0] s, input int n, input int ew);
        int e = 0;
        for (int k = 1; k < n; k++) begin
            int c = 0;
            for (int i = 0; i < n - k; i++) c += (s[i] == s[i+k]) ? 1 : -1;
            e += c * c;
        end
        if (e > (1 << ew) - 1) e = (1 << ew) - 1;
        return e;
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 1) ? 13 : 16;
    endfunction

    task automatic run_vec(input int sel, input logic [15:0] seq, input int exp_e, input bit bp);
        int   n = width_of(sel);
        int   lat = 0;
        exp_t e;
        @(negedge clk);
        chk("in_ready_idle", int'(ir[sel]), 1);
        is_[sel]  = seq;
        iv[sel]   = 1'b1;
        ordy[sel] = !bp;
        sb.push_back('{seq & 16'((1 << n) - 1), exp_e, n});
        do begin
            @(negedge clk);
            lat++;
            iv[sel]  = 1'b0;
            is_[sel] = ~seq;
            if (!ov[sel] && lat < n) chk("in_ready_busy", int'(ir[sel]), 0);
        end while (!ov[sel] && lat < 200);
        e = sb.pop_front();
        if (!ov[sel]) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        chk("latency", lat, e.lat);
        chk("out_seq", int'(os[sel]), int'(e.seq));
        chk("out_energy", int'(oe[sel]), e.energy);
        if (bp) begin
            repeat (5) begin
                iv[sel]  = 1'b1;
                is_[sel] = 16'h1234;
                @(negedge clk);
                chk("bp_out_valid", int'(ov[sel]), 1);
                chk("bp_out_seq", int'(os[sel]), int'(e.seq));
                chk("bp_out_energy", int'(oe[sel]), e.energy);
                chk("bp_in_ready", int'(ir[sel]), 0);
            end
            iv[sel]   = 1'b0;
            ordy[sel] = 1'b1;
        end
        @(negedge clk);
        chk("post_hs_out_valid", int'(ov[sel]), 0);
        chk("post_hs_in_ready", int'(ir[sel]), 1);
        chk("post_hs_busy", int'(bsy[sel]), 0);
    endtask

    initial begin
        logic [15:0] r;
        int          ov_seen;

        rst  = 1'b1;
        iv   = '0;
        ordy = '1;
        for (int i = 0; i < 3; i++) begin
            is_[i] = '0;
            eb[i]  = 16'hFFFF;
        end

        vecs.push_back('{0, 16'hFFFF, 1240, 1'b0});
        vecs.push_back('{1, 16'h1F35, 6,    1'b0});
        vecs.push_back('{0, 16'h5555, 1240, 1'b0});
        vecs.push_back('{0, 16'h0000, 1240, 1'b0});
        vecs.push_back('{0, 16'hA5C3, model_energy(16'hA5C3, 16, 16), 1'b1});
`ifndef LABS_EARLY_ABORT_EN
        vecs.push_back('{2, 16'hFFFF, 255, 1'b0});
        vecs.push_back('{2, 16'h1F35, model_energy(16'h1F35, 16, 8), 1'b0});
`endif
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            vecs.push_back('{0, r, model_energy(r, 16, 16), 1'b0});
            r = 16'($urandom);
            vecs.push_back('{1, r, model_energy(r, 13, 16), 1'b0});
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", int'(ir[i]), 0);
            chk("rst_out_valid", int'(ov[i]), 0);
            chk("rst_busy", int'(bsy[i]), 0);
            chk("rst_out_seq", int'(os[i]), 0);
            chk("rst_out_energy", int'(oe[i]), 0);
        end
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i].sel, vecs[i].seq, vecs[i].exp_e, vecs[i].bp);

        // Reset in the 4th CALC cycle discards the candidate.
        @(negedge clk);
        iv[0] = 1'b1;
        is_[0] = 16'hFFFF;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(bsy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_out_valid", int'(ov[0]), 0);
        chk("midrst_in_ready", int'(ir[0]), 0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready_after", int'(ir[0]), 1);
        ov_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov != 3'b000) ov_seen++;
        end
        chk("midrst_no_output", ov_seen, 0);
        run_vec(0, 16'hFFFF, 1240, 1'b0);

`ifdef LABS_EARLY_ABORT_EN
        eb[0] = 16'd100;
        @(negedge clk);
        iv[0] = 1'b1;
        is_[0] = 16'hFFFF;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("abort_calc_busy", int'(bsy[0]), 1);
        @(negedge clk);
        chk("abort_in_ready", int'(ir[0]), 1);
        chk("abort_busy", int'(bsy[0]), 0);
        ov_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) ov_seen++;
        end
        chk("abort_no_output", ov_seen, 0);
        eb[0] = 16'd1240;
        run_vec(0, 16'hFFFF, 1240, 1'b0);
        eb[0] = 16'hFFFF;
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
